// File: rtl/toy_bus_darb_node_agemtx_param.sv
// ---------------------------------------------------------------------------
// toy_bus_darb_node_agemtx_param
//
// N-input arbitration node for the toy bus ack network. Merges N_IN
// valid/ready channels into one output using an age matrix that implements
// least-recently-granted arbitration. Optional burst locking (LOCK_EN) keeps
// the grant on one port until a beat with last=1 is accepted. Optional output
// register slice (FORWARD) breaks the output timing path at full throughput.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_vld/in_rdy     per-channel handshake (N_IN bits each)
//   in_opcode/in_last per-channel 1-bit fields
//   in_data           N_IN*DATA_W, channel i at [i*DATA_W +: DATA_W]
//   in_sideband       N_IN*SB_W, packed the same way
//   in_src_id/tgt_id  N_IN*ID_W, packed the same way
//   out_vld/out_rdy   output handshake
//   out_*             selected payload
// ---------------------------------------------------------------------------
module toy_bus_darb_node_agemtx_param #(
  parameter int N_IN    = 4,
  parameter int DATA_W  = 256,
  parameter int SB_W    = 32,
  parameter int ID_W    = 4,
  parameter int LOCK_EN = 1,
  parameter int FORWARD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          in_vld,
  output logic [N_IN-1:0]          in_rdy,
  input  logic [N_IN-1:0]          in_opcode,
  input  logic [N_IN-1:0]          in_last,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN*SB_W-1:0]     in_sideband,
  input  logic [N_IN*ID_W-1:0]     in_src_id,
  input  logic [N_IN*ID_W-1:0]     in_tgt_id,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_opcode,
  output logic                     out_last,
  output logic [DATA_W-1:0]        out_data,
  output logic [SB_W-1:0]          out_sideband,
  output logic [ID_W-1:0]          out_src_id,
  output logic [ID_W-1:0]          out_tgt_id
);

  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_e;

  logic [N_IN-1:0] w_age [N_IN];  // w_age[i][j]=1: j is older, i yields to j
  logic [N_IN-1:0] w_sel;
  logic [N_IN-1:0] w_grant;
  logic [N_IN-1:0] w_acc;         // accepted beat this cycle (at most one bit)
  logic [N_IN-1:0] w_fire;        // accepted beat that ends a grant

  assign w_acc  = in_vld & in_rdy;
  assign w_fire = (LOCK_EN != 0) ? (w_acc & in_last) : w_acc;

  // Age matrix: only off-diagonal bits get a flop. A finishing channel g sets
  // its own row (everyone is older than g) and clears its column.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_row
    for (genvar gj = 0; gj < N_IN; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        assign w_age[gi][gj] = 1'b0;
      end else begin : g_cell
        logic r_age_bit;
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of evaluation order.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)            r_age_bit <= (gj < gi);
          else if (w_fire[gi])   r_age_bit <= 1'b1;
          else if (w_fire[gj])   r_age_bit <= 1'b0;
        end
        assign w_age[gi][gj] = r_age_bit;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_sel[i] = in_vld[i] & ~|(w_age[i] & in_vld);
    end
  end

  // Burst lock FSM
  lock_state_e     r_state, w_state_nxt;
  logic [N_IN-1:0] r_lock_port, w_lock_port_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_port <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_port <= w_lock_port_nxt;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_lock_port_nxt = r_lock_port;
    case (r_state)
      ST_IDLE: begin
        if ((LOCK_EN != 0) && |(w_acc & ~in_last)) begin
          w_state_nxt     = ST_LOCKED;
          w_lock_port_nxt = w_acc;
        end
      end
      ST_LOCKED: begin
        // Only the locked port can be ready, so any accepted last ends it.
        if (|(w_acc & in_last)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_grant = (r_state == ST_LOCKED) ? r_lock_port : w_sel;

  // AND-OR payload mux on the one-hot grant
  logic              w_vld;
  logic              w_opcode, w_last;
  logic [DATA_W-1:0] w_data;
  logic [SB_W-1:0]   w_sb;
  logic [ID_W-1:0]   w_src, w_tgt;

  assign w_vld = |(in_vld & w_grant);

  always_comb begin
    w_opcode = 1'b0;
    w_last   = 1'b0;
    w_data   = '0;
    w_sb     = '0;
    w_src    = '0;
    w_tgt    = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant[i]) begin
        w_opcode = w_opcode | in_opcode[i];
        w_last   = w_last   | in_last[i];
        w_data   = w_data   | in_data[i*DATA_W +: DATA_W];
        w_sb     = w_sb     | in_sideband[i*SB_W +: SB_W];
        w_src    = w_src    | in_src_id[i*ID_W +: ID_W];
        w_tgt    = w_tgt    | in_tgt_id[i*ID_W +: ID_W];
      end
    end
  end

  if (FORWARD != 0) begin : g_fwd
    logic              r_vld;
    logic              r_opcode, r_last;
    logic [DATA_W-1:0] r_data;
    logic [SB_W-1:0]   r_sb;
    logic [ID_W-1:0]   r_src, r_tgt;

    // Load whenever the slot is empty or draining this cycle.
    assign in_rdy = w_grant & {N_IN{~r_vld | out_rdy}};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: payload registers are reset too, because out_* must read
        // zero after reset rather than whatever the slice last held.
        r_vld    <= 1'b0;
        r_opcode <= 1'b0;
        r_last   <= 1'b0;
        r_data   <= '0;
        r_sb     <= '0;
        r_src    <= '0;
        r_tgt    <= '0;
      end else if (|w_acc) begin
        r_vld    <= 1'b1;
        r_opcode <= w_opcode;
        r_last   <= w_last;
        r_data   <= w_data;
        r_sb     <= w_sb;
        r_src    <= w_src;
        r_tgt    <= w_tgt;
      end else if (out_rdy) begin
        r_vld    <= 1'b0;
      end
    end

    assign out_vld      = r_vld;
    assign out_opcode   = r_opcode;
    assign out_last     = r_last;
    assign out_data     = r_data;
    assign out_sideband = r_sb;
    assign out_src_id   = r_src;
    assign out_tgt_id   = r_tgt;
  end else begin : g_comb
    assign in_rdy       = w_grant & {N_IN{out_rdy}};
    assign out_vld      = w_vld;
    assign out_opcode   = w_opcode;
    assign out_last     = w_last;
    assign out_data     = w_data;
    assign out_sideband = w_sb;
    assign out_src_id   = w_src;
    assign out_tgt_id   = w_tgt;
  end

endmodule
